// File: rtl/psum_accum_sfu_pkg.sv
// Shared definitions for the partial-sum accumulator / special-function unit.
// Holds the drain FSM state encoding and the signed saturation limits used by
// every lane adder.
package psum_accum_sfu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Largest value representable in a bw-bit two's complement word.
  function automatic logic signed [63:0] sat_max(input int bw);
    return (64'sd1 <<< (bw - 1)) - 64'sd1;
  endfunction

  // Smallest value representable in a bw-bit two's complement word.
  function automatic logic signed [63:0] sat_min(input int bw);
    return -(64'sd1 <<< (bw - 1));
  endfunction

endpackage

// File: rtl/psum_accum_sfu_sat_add.sv
// Single-lane signed saturating adder.
// Ports:
//   a, b : signed psum_bw-bit operands
//   y    : a + b clamped to the signed psum_bw-bit range
module sat_add
  import psum_accum_sfu_pkg::*;
#(
  parameter int psum_bw = 16
) (
  input  logic [psum_bw-1:0] a,
  input  logic [psum_bw-1:0] b,
  output logic [psum_bw-1:0] y
);

  localparam logic [psum_bw-1:0] max_v = psum_bw'(sat_max(psum_bw));
  localparam logic [psum_bw-1:0] min_v = psum_bw'(sat_min(psum_bw));

  logic [psum_bw:0] sum;

  // One guard bit; overflow shows up as the top two bits disagreeing.
  assign sum = {a[psum_bw-1], a} + {b[psum_bw-1], b};

  always_comb begin
    y = sum[psum_bw-1:0];
    if (sum[psum_bw] != sum[psum_bw-1]) begin
      y = sum[psum_bw] ? min_v : max_v;
    end
  end

endmodule

// File: rtl/psum_accum_sfu.sv
// Partial-sum accumulation buffer with ReLU drain.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | accepts accumulate writes, mode loads and flush_start
// FLUSH | presents entry rd_ptr on out_data, advances on out_ready
// DONE  | one-cycle completion pulse, then back to IDLE
//
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   in_psum, valid_in   : per-lane MAC results and write strobes
//   acc_addr, acc_first : target entry, overwrite instead of accumulate
//   relu_en, relu_ld    : ReLU mode value and its load strobe
//   flush_start         : begin draining entries 0..depth-1
//   clear_on_flush      : zero each entry as it is handshaken
//   out_data, out_valid, out_ready : drained row and its handshake
//   busy, done, err     : not idle, completion pulse, sticky collision flag
module psum_accum_sfu
  import psum_accum_sfu_pkg::*;
#(
  parameter int col          = 8,
  parameter int psum_bw      = 16,
  parameter int depth        = 16,
  parameter int relu_default = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [col*psum_bw-1:0]     in_psum,
  input  logic [col-1:0]             valid_in,
  input  logic [$clog2(depth)-1:0]   acc_addr,
  input  logic                       acc_first,
  input  logic                       relu_en,
  input  logic                       relu_ld,
  input  logic                       flush_start,
  input  logic                       clear_on_flush,
  output logic [col*psum_bw-1:0]     out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int aw = $clog2(depth);
  localparam logic [aw-1:0] last_addr = aw'(depth - 1);

  state_t state, state_nxt;

  logic [col-1:0][psum_bw-1:0] mem [depth];
  logic [col-1:0][psum_bw-1:0] acc_row;
  logic [col-1:0][psum_bw-1:0] sum_row;
  logic [col-1:0][psum_bw-1:0] drain_row;
  logic [aw-1:0]               rd_ptr;
  logic                        mode;
  logic                        clear_r;
  logic                        hs;

  assign acc_row   = mem[acc_addr];
  assign drain_row = mem[rd_ptr];
  assign hs        = out_valid && out_ready;

  // Combinational read feeds the adders so a write to the same entry on the
  // following cycle already sees the updated value (no stall, no bypass).
  for (genvar i = 0; i < col; i++) begin : g_lane
    sat_add #(.psum_bw(psum_bw)) u_sat_add (
      .a (acc_row[i]),
      .b (in_psum[i*psum_bw +: psum_bw]),
      .y (sum_row[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (flush_start) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        out_valid = 1'b1;
        if (out_ready && (rd_ptr == last_addr)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output is derived straight from the entry under rd_ptr; it cannot move
  // while stalled because rd_ptr and the memory are frozen during FLUSH.
  always_comb begin
    out_data = '0;
    if (out_valid) begin
      for (int i = 0; i < col; i++) begin
        out_data[i*psum_bw +: psum_bw] =
          (mode && drain_row[i][psum_bw-1]) ? '0 : drain_row[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < depth; e++) mem[e] <= '0;
      rd_ptr  <= '0;
      mode    <= (relu_default != 0);
      clear_r <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (busy && (|valid_in)) err <= 1'b1;
      if (state == ST_IDLE) begin
        for (int i = 0; i < col; i++) begin
          if (valid_in[i]) begin
            mem[acc_addr][i] <= acc_first ? in_psum[i*psum_bw +: psum_bw] : sum_row[i];
          end
        end
        if (relu_ld) mode <= relu_en;
        if (flush_start) begin
          clear_r <= clear_on_flush;
          rd_ptr  <= '0;
        end
      end
      if (hs) begin
        // Wraps to 0 after the last entry since depth is a power of two.
        rd_ptr <= rd_ptr + aw'(1);
        if (clear_r) mem[rd_ptr] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_psum_accum_sfu.sv
module tb_psum_accum_sfu;

  localparam int col     = 8;
  localparam int psum_bw = 16;
  localparam int depth   = 16;
  localparam int aw      = $clog2(depth);
  localparam int hi_lim  = (1 << (psum_bw - 1)) - 1;
  localparam int lo_lim  = -(1 << (psum_bw - 1));

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic [col*psum_bw-1:0] in_psum;
  logic [col-1:0]         valid_in;
  logic [aw-1:0]          acc_addr;
  logic                   acc_first;
  logic                   relu_en;
  logic                   relu_ld;
  logic                   flush_start;
  logic                   clear_on_flush;
  logic [col*psum_bw-1:0] out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   busy;
  logic                   done;
  logic                   err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  psum_accum_sfu #(
    .col(col), .psum_bw(psum_bw), .depth(depth), .relu_default(1)
  ) dut (
    .clk(clk), .reset(reset), .in_psum(in_psum), .valid_in(valid_in),
    .acc_addr(acc_addr), .acc_first(acc_first), .relu_en(relu_en),
    .relu_ld(relu_ld), .flush_start(flush_start),
    .clear_on_flush(clear_on_flush), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .done(done), .err(err)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int lane_of(input logic [col*psum_bw-1:0] v, input int i);
    return int'($signed(v[i*psum_bw +: psum_bw]));
  endfunction

  function automatic int clamp(input int s);
    if (s > hi_lim) return hi_lim;
    if (s < lo_lim) return lo_lim;
    return s;
  endfunction

  // Behavioural model: integer memory, a mode bit, a sticky error bit and a
  // "drain in progress" cursor over the entries.
  int m_mem [depth][col];
  bit m_mode, m_err, m_clear, m_flushing, m_done, m_busy;
  int m_idx;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < depth; e++)
        for (int i = 0; i < col; i++) m_mem[e][i] = 0;
      m_mode = 1'b1; m_err = 1'b0; m_clear = 1'b0;
      m_flushing = 1'b0; m_done = 1'b0; m_idx = 0;
    end else begin
      m_busy = m_flushing || m_done;
      if (m_done) begin
        m_done = 1'b0;
      end else if (m_flushing) begin
        if (out_ready) begin
          if (m_clear)
            for (int i = 0; i < col; i++) m_mem[m_idx][i] = 0;
          if (m_idx == depth - 1) begin
            m_flushing = 1'b0;
            m_done = 1'b1;
          end
          m_idx++;
        end
      end else begin
        for (int i = 0; i < col; i++)
          if (valid_in[i])
            m_mem[acc_addr][i] = acc_first ? lane_of(in_psum, i)
                                           : clamp(m_mem[acc_addr][i] + lane_of(in_psum, i));
        if (relu_ld) m_mode = relu_en;
        if (flush_start) begin
          m_flushing = 1'b1;
          m_idx = 0;
          m_clear = clear_on_flush;
        end
      end
      if (m_busy && (|valid_in)) m_err = 1'b1;
    end
  end

  always @(negedge clk) begin
    check("busy", busy, m_flushing || m_done);
    check("done", done, m_done);
    check("out_valid", out_valid, m_flushing);
    check("err", err, m_err);
    if (m_flushing) begin
      for (int i = 0; i < col; i++)
        check("out_lane", lane_of(out_data, i),
              (m_mode && m_mem[m_idx][i] < 0) ? 0 : m_mem[m_idx][i]);
    end
  end

  logic [col*psum_bw-1:0] got [depth];

  task automatic idle();
    @(negedge clk);
    valid_in = '0; acc_first = 1'b0; relu_ld = 1'b0;
    flush_start = 1'b0; clear_on_flush = 1'b0;
  endtask

  task automatic acc(input int addr, input bit first, input logic [col-1:0] mask, input int val);
    @(negedge clk);
    acc_addr = aw'(addr);
    acc_first = first;
    valid_in = mask;
    for (int i = 0; i < col; i++) in_psum[i*psum_bw +: psum_bw] = psum_bw'(val);
  endtask

  task automatic do_flush(input bit clr, input bit toggle, input bit inject, input int abort_at,
                          output int cycles, output int ndone, output int nhs);
    logic [3:0] pat;
    logic [col*psum_bw-1:0] prev;
    bit stalled, finished;
    pat = 4'b1001;
    @(negedge clk);
    flush_start = 1'b1; clear_on_flush = clr; out_ready = 1'b1; valid_in = '0;
    @(negedge clk);
    flush_start = 1'b0; clear_on_flush = 1'b0;
    cycles = 1; ndone = 0; nhs = 0; stalled = 1'b0; finished = 1'b0; prev = '0;
    for (int k = 0; k < 200 && !finished; k++) begin
      if (k > 0) @(negedge clk);
      cycles++;
      valid_in = (inject && k == 0) ? col'(1) : '0;
      acc_addr = '0; acc_first = 1'b1;
      for (int i = 0; i < col; i++) in_psum[i*psum_bw +: psum_bw] = psum_bw'(16'h1234);
      if (abort_at >= 0 && nhs == abort_at) begin
        #2 reset = 1'b1;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        repeat (3) begin
          @(negedge clk);
          check("abort_no_done", done, 0);
        end
        #2 reset = 1'b0;
        finished = 1'b1;
      end else begin
        out_ready = toggle ? pat[k % 4] : 1'b1;
        if (stalled && out_valid) check("stall_hold", (out_data == prev), 1);
        if (done) begin
          ndone++;
          finished = 1'b1;
        end
        if (out_valid && out_ready) begin
          got[nhs % depth] = out_data;
          nhs++;
        end
        stalled = out_valid && !out_ready;
        prev = out_data;
      end
    end
    valid_in = '0; acc_first = 1'b0; out_ready = 1'b1;
    if (!finished) check("flush_timeout", 0, 1);
  endtask

  int cyc, nd, nh, bad;

  initial begin
    in_psum = '0; valid_in = '0; acc_addr = '0; acc_first = 1'b0;
    relu_en = 1'b0; relu_ld = 1'b0; flush_start = 1'b0;
    clear_on_flush = 1'b0; out_ready = 1'b1;
    #1 reset = 1'b1;
    @(negedge clk); #1;
    check("rst_out_data", (out_data == '0), 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_done", done, 0);
    @(negedge clk); #2 reset = 1'b0;

    // Back-to-back accumulate into entry 2, lane 0: 5 + 7 - 3 = 9
    acc(2, 1, 8'h01, 5);
    acc(2, 0, 8'h01, 7);
    acc(2, 0, 8'h01, -3);
    idle();
    check("model_acc", m_mem[2][0], 9);
    do_flush(0, 0, 0, -1, cyc, nd, nh);
    check("acc_entry2", lane_of(got[2], 0), 9);
    check("acc_lane1_untouched", lane_of(got[2], 1), 0);
    check("flush_cycles", cyc, depth + 2);
    check("flush_done_count", nd, 1);
    check("flush_entries", nh, depth);

    // ReLU on (reset default) then off
    acc(0, 1, 8'h01, -4);
    idle();
    do_flush(0, 0, 0, -1, cyc, nd, nh);
    check("relu_on", lane_of(got[0], 0), 0);
    @(negedge clk);
    relu_en = 1'b0; relu_ld = 1'b1;
    idle();
    do_flush(0, 0, 0, -1, cyc, nd, nh);
    check("relu_off", got[0][psum_bw-1:0], 16'hFFFC);

    // Saturation and in-order drain under out_ready stalls
    acc(3, 1, 8'h02, 32000);
    acc(3, 0, 8'h02, 1000);
    acc(4, 1, 8'h02, -32000);
    acc(4, 0, 8'h02, -1000);
    for (int e = 0; e < depth; e++) acc(e, 1, 8'h04, e + 1);
    idle();
    check("model_sat_hi", m_mem[3][1], 32767);
    check("model_sat_lo", m_mem[4][1], -32768);
    do_flush(0, 1, 0, -1, cyc, nd, nh);
    check("sat_hi", lane_of(got[3], 1), 32767);
    check("sat_lo", lane_of(got[4], 1), -32768);
    bad = 0;
    for (int e = 0; e < depth; e++) if (lane_of(got[e], 2) != e + 1) bad++;
    check("stall_order", bad, 0);
    check("stall_entries", nh, depth);
    check("stall_done_count", nd, 1);
    check("stall_seen", (cyc > depth + 2), 1);

    // Write during flush is dropped and flags err; clear_on_flush empties memory
    do_flush(0, 0, 1, -1, cyc, nd, nh);
    check("err_sticky", err, 1);
    check("err_mem_kept", got[0][psum_bw-1:0], 16'hFFFC);
    check("err_lane1_kept", lane_of(got[0], 1), 0);
    do_flush(1, 0, 0, -1, cyc, nd, nh);
    do_flush(0, 0, 0, -1, cyc, nd, nh);
    bad = 0;
    for (int e = 0; e < depth; e++) if (got[e] != '0) bad++;
    check("clear_zeros", bad, 0);
    check("clear_entries", nh, depth);
    check("err_still_set", err, 1);

    // Reset mid-drain
    @(negedge clk); #2 reset = 1'b1;
    @(negedge clk); #2 reset = 1'b0;
    check("err_cleared", err, 0);
    for (int e = 0; e < depth; e++) acc(e, 1, 8'hFF, e + 10);
    idle();
    do_flush(0, 0, 0, 5, cyc, nd, nh);
    check("abort_handshakes", nh, 5);
    check("abort_done_count", nd, 0);
    do_flush(0, 0, 0, -1, cyc, nd, nh);
    bad = 0;
    for (int e = 0; e < depth; e++) if (got[e] != '0) bad++;
    check("post_reset_zeros", bad, 0);
    check("post_reset_done", nd, 1);
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
